// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
package regfile_pkg;

  localparam int unsigned REG_ADDR_W = 4;
  localparam int unsigned REG_DATA_W = 32;

  localparam logic [REG_ADDR_W-1:0] PC_ADDR = 4'd15;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_MEM,
    GNT_ALU
  } gnt_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of writeback requests; exposes every slot's
// address and valid bit so the arbiter can search for pending writes.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  wb_req_t                       push_req,
  input  logic                          pop,
  output logic                          full,
  output logic                          empty,
  output wb_req_t                       head,
  output logic [DEPTH*REG_ADDR_W-1:0]   entry_addr,
  output logic [DEPTH-1:0]              entry_valid
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  wb_req_t            mem [DEPTH];
  logic [DEPTH-1:0]   valid;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               push_ok;
  logic               pop_ok;

  assign full    = &valid;
  assign empty   = ~|valid;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Per-slot valid bits replace a count; push may land in the slot a pop frees
  // only when full, which push_ok excludes, so the two never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (pop_ok) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end
      if (push_ok) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_req;
    end
  end

  always_comb begin
    entry_addr = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_addr[i*REG_ADDR_W +: REG_ADDR_W] = mem[i].addr;
    end
  end

  assign entry_valid = valid;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between a queued ALU
// writeback stream and direct memory writebacks, with hazard lookups.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ALU_FIFO_DEPTH = 2,
  parameter int unsigned MAX_MEM_BURST  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_alu_valid,
  output logic              o_alu_ready,
  input  logic [ADDR_W-1:0] i_alu_addr,
  input  logic [DATA_W-1:0] i_alu_data,
  input  logic              i_mem_valid,
  output logic              o_mem_ready,
  input  logic [ADDR_W-1:0] i_mem_addr,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic [ADDR_W-1:0] o_addr_rd,
  output logic [DATA_W-1:0] o_rd,
  output logic              o_rd_wr_en,
  output logic              o_pc_wr,
  input  logic [ADDR_W-1:0] i_addr_rn,
  input  logic [ADDR_W-1:0] i_addr_rt,
  output logic              o_pend_rn,
  output logic              o_pend_rt
);

  localparam int unsigned BURST_W = $clog2(MAX_MEM_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_MEM_BURST);

  logic                             fifo_full;
  logic                             fifo_empty;
  logic                             fifo_push;
  logic                             fifo_pop;
  wb_req_t                          fifo_head;
  wb_req_t                          alu_req;
  wb_req_t                          gnt_req;
  logic [ALU_FIFO_DEPTH*ADDR_W-1:0] entry_addr;
  logic [ALU_FIFO_DEPTH-1:0]        entry_valid;
  logic [BURST_W-1:0]               burst_cnt;
  logic                             conflict;
  logic                             force_alu;
  logic                             hit_rn;
  logic                             hit_rt;
  gnt_src_e                         gnt;

  assign alu_req   = '{addr: i_alu_addr, data: i_alu_data};
  assign fifo_push = i_alu_valid & o_alu_ready;
  assign fifo_pop  = (gnt == GNT_ALU);

  wb_fifo #(
    .DEPTH (ALU_FIFO_DEPTH)
  ) u_alu_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (fifo_push),
    .push_req    (alu_req),
    .pop         (fifo_pop),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .head        (fifo_head),
    .entry_addr  (entry_addr),
    .entry_valid (entry_valid)
  );

  always_comb begin
    conflict = 1'b0;
    hit_rn   = 1'b0;
    hit_rt   = 1'b0;
    for (int unsigned i = 0; i < ALU_FIFO_DEPTH; i++) begin
      if (entry_valid[i]) begin
        if (entry_addr[i*ADDR_W +: ADDR_W] == i_mem_addr) conflict = 1'b1;
        if (entry_addr[i*ADDR_W +: ADDR_W] == i_addr_rn)  hit_rn   = 1'b1;
        if (entry_addr[i*ADDR_W +: ADDR_W] == i_addr_rt)  hit_rt   = 1'b1;
      end
    end
  end

  // A queued ALU write to the same register is older, so memory must wait.
  assign force_alu   = (burst_cnt == BURST_MAX) & ~fifo_empty;
  assign o_alu_ready = ~rst & ~fifo_full;
  assign o_mem_ready = ~rst & ~conflict & ~force_alu;

  assign o_pend_rn = hit_rn | (o_rd_wr_en & (o_addr_rd == i_addr_rn));
  assign o_pend_rt = hit_rt | (o_rd_wr_en & (o_addr_rd == i_addr_rt));

  always_comb begin
    gnt     = GNT_NONE;
    gnt_req = fifo_head;
    if (i_mem_valid & o_mem_ready) begin
      gnt     = GNT_MEM;
      gnt_req = '{addr: i_mem_addr, data: i_mem_data};
    end else if (!fifo_empty) begin
      gnt     = GNT_ALU;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (gnt == GNT_ALU || fifo_empty) begin
      burst_cnt <= '0;
    end else if (gnt == GNT_MEM && burst_cnt != BURST_MAX) begin
      burst_cnt <= burst_cnt + BURST_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_addr_rd  <= '0;
      o_rd       <= '0;
      o_rd_wr_en <= 1'b0;
      o_pc_wr    <= 1'b0;
    end else if (gnt == GNT_NONE) begin
      o_rd_wr_en <= 1'b0;
      o_pc_wr    <= 1'b0;
    end else begin
      o_addr_rd  <= gnt_req.addr;
      o_rd       <= gnt_req.data;
      o_rd_wr_en <= 1'b1;
      o_pc_wr    <= (gnt_req.addr == PC_ADDR);
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter with hand-computed
// expectations plus sequences for burst limiting and mid-operation reset.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_alu_valid;
  logic        o_alu_ready;
  logic [3:0]  i_alu_addr;
  logic [31:0] i_alu_data;
  logic        i_mem_valid;
  logic        o_mem_ready;
  logic [3:0]  i_mem_addr;
  logic [31:0] i_mem_data;
  logic [3:0]  o_addr_rd;
  logic [31:0] o_rd;
  logic        o_rd_wr_en;
  logic        o_pc_wr;
  logic [3:0]  i_addr_rn;
  logic [3:0]  i_addr_rt;
  logic        o_pend_rn;
  logic        o_pend_rt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .ADDR_W         (4),
    .DATA_W         (32),
    .ALU_FIFO_DEPTH (2),
    .MAX_MEM_BURST  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_alu_valid (i_alu_valid),
    .o_alu_ready (o_alu_ready),
    .i_alu_addr  (i_alu_addr),
    .i_alu_data  (i_alu_data),
    .i_mem_valid (i_mem_valid),
    .o_mem_ready (o_mem_ready),
    .i_mem_addr  (i_mem_addr),
    .i_mem_data  (i_mem_data),
    .o_addr_rd   (o_addr_rd),
    .o_rd        (o_rd),
    .o_rd_wr_en  (o_rd_wr_en),
    .o_pc_wr     (o_pc_wr),
    .i_addr_rn   (i_addr_rn),
    .i_addr_rt   (i_addr_rt),
    .o_pend_rn   (o_pend_rn),
    .o_pend_rt   (o_pend_rt)
  );

  typedef struct {
    logic        av;
    logic [3:0]  aa;
    logic [31:0] ad;
    logic        mv;
    logic [3:0]  ma;
    logic [31:0] md;
    logic [3:0]  rn;
    logic [3:0]  rt;
    logic        e_ar;
    logic        e_mr;
    logic        e_we;
    logic [3:0]  e_addr;
    logic [31:0] e_rd;
    logic        e_pc;
    logic        e_pn;
    logic        e_pt;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [3:0] aa, input logic [31:0] ad,
                       input logic mv, input logic [3:0] ma, input logic [31:0] md);
    i_alu_valid = av; i_alu_addr = aa; i_alu_data = ad;
    i_mem_valid = mv; i_mem_addr = ma; i_mem_data = md;
  endtask

  // Called at posedge+1; leaves the bench at the next posedge+1.
  task automatic apply(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    drive(v.av, v.aa, v.ad, v.mv, v.ma, v.md);
    i_addr_rn = v.rn;
    i_addr_rt = v.rt;
    #1;
    check({tag, "_alu_ready"}, 32'(o_alu_ready), 32'(v.e_ar));
    check({tag, "_mem_ready"}, 32'(o_mem_ready), 32'(v.e_mr));
    @(posedge clk);
    #1;
    check({tag, "_wr_en"},   32'(o_rd_wr_en), 32'(v.e_we));
    check({tag, "_addr_rd"}, 32'(o_addr_rd),  32'(v.e_addr));
    check({tag, "_rd"},      o_rd,            v.e_rd);
    check({tag, "_pc_wr"},   32'(o_pc_wr),    32'(v.e_pc));
    check({tag, "_pend_rn"}, 32'(o_pend_rn),  32'(v.e_pn));
    check({tag, "_pend_rt"}, 32'(o_pend_rt),  32'(v.e_pt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int unsigned k;
    logic        exp_mr;

    //          av  aa     ad          mv  ma     md            rn     rt     ar mr we addr   rd            pc pn pt
    vecs[0]  = '{0, 4'd0,  32'h0,      0, 4'd0, 32'h0,        4'd3,  4'd0,  1, 1, 0, 4'd0,  32'h0,        0, 0, 0};
    vecs[1]  = '{0, 4'd0,  32'h0,      1, 4'd3, 32'hDEADBEEF, 4'd3,  4'd0,  1, 1, 1, 4'd3,  32'hDEADBEEF, 0, 1, 0};
    vecs[2]  = '{0, 4'd0,  32'h0,      0, 4'd0, 32'h0,        4'd3,  4'd0,  1, 1, 0, 4'd3,  32'hDEADBEEF, 0, 0, 0};
    vecs[3]  = '{1, 4'd1,  32'h11,     0, 4'd0, 32'h0,        4'd1,  4'd2,  1, 1, 0, 4'd3,  32'hDEADBEEF, 0, 1, 0};
    vecs[4]  = '{1, 4'd2,  32'h22,     0, 4'd0, 32'h0,        4'd1,  4'd2,  1, 1, 1, 4'd1,  32'h11,       0, 1, 1};
    vecs[5]  = '{0, 4'd0,  32'h0,      0, 4'd0, 32'h0,        4'd1,  4'd2,  1, 1, 1, 4'd2,  32'h22,       0, 0, 1};
    vecs[6]  = '{0, 4'd0,  32'h0,      0, 4'd0, 32'h0,        4'd1,  4'd2,  1, 1, 0, 4'd2,  32'h22,       0, 0, 0};
    vecs[7]  = '{1, 4'd4,  32'h44,     0, 4'd0, 32'h0,        4'd4,  4'd0,  1, 1, 0, 4'd2,  32'h22,       0, 1, 0};
    vecs[8]  = '{0, 4'd0,  32'h0,      1, 4'd4, 32'h55,       4'd4,  4'd0,  1, 0, 1, 4'd4,  32'h44,       0, 1, 0};
    vecs[9]  = '{0, 4'd0,  32'h0,      1, 4'd4, 32'h55,       4'd4,  4'd0,  1, 1, 1, 4'd4,  32'h55,       0, 1, 0};
    vecs[10] = '{0, 4'd0,  32'h0,      0, 4'd0, 32'h0,        4'd4,  4'd0,  1, 1, 0, 4'd4,  32'h55,       0, 0, 0};
    vecs[11] = '{1, 4'd15, 32'h100,    0, 4'd0, 32'h0,        4'd15, 4'd14, 1, 1, 0, 4'd4,  32'h55,       0, 1, 0};
    vecs[12] = '{1, 4'd14, 32'hE0,     0, 4'd0, 32'h0,        4'd15, 4'd14, 1, 1, 1, 4'd15, 32'h100,      1, 1, 1};
    vecs[13] = '{0, 4'd0,  32'h0,      0, 4'd0, 32'h0,        4'd15, 4'd14, 1, 1, 1, 4'd14, 32'hE0,       0, 0, 1};
    vecs[14] = '{0, 4'd0,  32'h0,      0, 4'd0, 32'h0,        4'd15, 4'd14, 1, 1, 0, 4'd14, 32'hE0,       0, 0, 0};
    vecs[15] = '{1, 4'd7,  32'h77,     1, 4'd9, 32'h99,       4'd7,  4'd8,  1, 1, 1, 4'd9,  32'h99,       0, 1, 0};
    vecs[16] = '{1, 4'd8,  32'h88,     1, 4'd9, 32'h9A,       4'd7,  4'd8,  1, 1, 1, 4'd9,  32'h9A,       0, 1, 1};
    vecs[17] = '{1, 4'd10, 32'hAA,     1, 4'd9, 32'h9B,       4'd7,  4'd8,  0, 1, 1, 4'd9,  32'h9B,       0, 1, 1};
    vecs[18] = '{1, 4'd10, 32'hAA,     0, 4'd9, 32'h0,        4'd7,  4'd8,  0, 1, 1, 4'd7,  32'h77,       0, 1, 1};
    vecs[19] = '{1, 4'd10, 32'hAA,     0, 4'd9, 32'h0,        4'd7,  4'd8,  1, 1, 1, 4'd8,  32'h88,       0, 0, 1};
    vecs[20] = '{0, 4'd0,  32'h0,      0, 4'd0, 32'h0,        4'd7,  4'd8,  1, 1, 1, 4'd10, 32'hAA,       0, 0, 0};
    vecs[21] = '{0, 4'd0,  32'h0,      0, 4'd0, 32'h0,        4'd7,  4'd8,  1, 1, 0, 4'd10, 32'hAA,       0, 0, 0};

    rst = 1'b1;
    drive(0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    i_addr_rn = 4'd0;
    i_addr_rt = 4'd0;
    #2;
    check("rst_alu_ready", 32'(o_alu_ready), 32'h0);
    check("rst_mem_ready", 32'(o_mem_ready), 32'h0);
    check("rst_wr_en",     32'(o_rd_wr_en),  32'h0);
    check("rst_addr_rd",   32'(o_addr_rd),   32'h0);
    check("rst_rd",        o_rd,             32'h0);
    check("rst_pc_wr",     32'(o_pc_wr),     32'h0);
    check("rst_pend_rn",   32'(o_pend_rn),   32'h0);
    check("rst_pend_rt",   32'(o_pend_rt),   32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      apply(i, vecs[i]);
    end

    // Burst limiter: one ALU entry queued, memory streams to r5.
    drive(1, 4'd6, 32'h66, 0, 4'd0, 32'h0);
    @(posedge clk);
    #1;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 4'd0, 32'h0, 1, 4'd5, 32'h500 + k);
      exp_mr = (i != 4);
      #1;
      check($sformatf("burst%0d_mem_ready", i), 32'(o_mem_ready), 32'(exp_mr));
      @(posedge clk);
      #1;
      check($sformatf("burst%0d_wr_en", i), 32'(o_rd_wr_en), 32'h1);
      check($sformatf("burst%0d_addr", i), 32'(o_addr_rd), exp_mr ? 32'd5 : 32'd6);
      check($sformatf("burst%0d_rd", i), o_rd, exp_mr ? (32'h500 + k) : 32'h66);
      if (exp_mr) k++;
    end
    drive(0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    @(posedge clk);
    #1;

    // Reset with two queued ALU entries and a write on the port.
    i_addr_rn = 4'd11;
    i_addr_rt = 4'd13;
    drive(1, 4'd11, 32'hB1, 1, 4'd12, 32'hC1);
    @(posedge clk);
    #1;
    drive(1, 4'd13, 32'hB2, 1, 4'd12, 32'hC2);
    @(posedge clk);
    #1;
    check("prerst_wr_en",     32'(o_rd_wr_en),  32'h1);
    check("prerst_alu_ready", 32'(o_alu_ready), 32'h0);
    check("prerst_pend_rn",   32'(o_pend_rn),   32'h1);
    check("prerst_pend_rt",   32'(o_pend_rt),   32'h1);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_wr_en",     32'(o_rd_wr_en),  32'h0);
    check("midrst_alu_ready", 32'(o_alu_ready), 32'h0);
    check("midrst_mem_ready", 32'(o_mem_ready), 32'h0);
    check("midrst_pend_rn",   32'(o_pend_rn),   32'h0);
    drive(0, 4'd0, 32'h0, 0, 4'd0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("postrst_alu_ready", 32'(o_alu_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("postrst%0d_wr_en", i), 32'(o_rd_wr_en), 32'h0);
      check($sformatf("postrst%0d_pend_rt", i), 32'(o_pend_rt), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
